m8088_hold_arbiter: RTL and testbench

- Shares the 8088 external bus between the CPU and NUM_REQ bus masters (blitter, DSP DMA) using the CPU HOLD/HOLDA handshake.
- Asserts HOLD toward the CPU and waits for HOLDA.
- Issues a one-hot grant to one requester, chosen round-robin.
- Sequences handover, preemption and release; sits beside m8088 at the top level.

---
 rtl/m8088_arb_pkg.sv | 44 ++++
 rtl/m8088_rr_picker.sv | 30 +++
 rtl/m8088_hold_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_m8088_hold_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/m8088_arb_pkg.sv
// Shared types and helpers for the 8088 HOLD/HOLDA bus arbiter.
package m8088_arb_pkg;

    localparam int RR_MAX_REQ     = 8;
    localparam int RR_IDX_W       = 3;
    localparam int DEF_MAX_TENURE = 64;
    localparam int CNT_W          = $clog2(DEF_MAX_TENURE + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        GRANT,
        HANDOVER,
        RELEASE,
        GAP
    } arb_state_t;

    // Tenure counter width for a given MAX_TENURE (at least one bit).
    function automatic int cnt_width(input int max_tenure);
        return (max_tenure > 0) ? $clog2(max_tenure + 1) : 1;
    endfunction

    // First set bit of req searching upward from last+1, modulo n; one-hot result.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   last,
        input int unsigned           n
    );
        logic [RR_MAX_REQ-1:0] pick;
        logic [RR_IDX_W-1:0]   idx;
        logic                  found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= n; i++) begin
            idx = RR_IDX_W'((32'(last) + i) % n);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/m8088_rr_picker.sv
// Combinational round-robin search over NUM_REQ (2..8) requesters.
import m8088_arb_pkg::*;

module m8088_rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [RR_IDX_W-1:0] last,
    output logic [NUM_REQ-1:0]  pick,
    output logic [RR_IDX_W-1:0] pick_idx,
    output logic                valid
);

    logic [RR_MAX_REQ-1:0] req_ext;
    logic [RR_MAX_REQ-1:0] pick_full;

    // Widen the request vector, search, and encode the winner's index.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick_full            = rr_pick(req_ext, last, NUM_REQ);
        pick                 = pick_full[NUM_REQ-1:0];
        valid                = |pick_full;
        pick_idx             = '0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            if (pick_full[i]) pick_idx = RR_IDX_W'(i);
        end
    end

endmodule

// File: rtl/m8088_hold_arbiter.sv
// Bus arbiter sharing the 8088 bus between the CPU and NUM_REQ masters
// via HOLD/HOLDA. Optional macro M8088_ARB_CPU_FAIRNESS_EN forces the CPU
// to regain the bus for CPU_GAP cycles between every tenure.
import m8088_arb_pkg::*;

module m8088_hold_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int MAX_TENURE = 64,
    parameter int CPU_GAP    = 8
) (
    input  logic               CORE_CLK,
    input  logic               RESET_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               HOLDA,
    output logic               HOLD,
    output logic [NUM_REQ-1:0] gnt,
    output logic               preempt,
    output logic               err
);

    localparam int TEN_W = cnt_width(MAX_TENURE);

    arb_state_t          state_q, state_n;
    logic                hold_n, preempt_n, err_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic [TEN_W-1:0]    cnt_q, cnt_n;
    logic [RR_IDX_W-1:0] rr_q, rr_n;
    logic [NUM_REQ-1:0]  pick;
    logic [RR_IDX_W-1:0] pick_idx;
    logic                pick_valid;
    logic                owner_req;
`ifdef M8088_ARB_CPU_FAIRNESS_EN
    localparam int GAP_W = (CPU_GAP > 1) ? $clog2(CPU_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CPU_GAP > 0) ? CPU_GAP - 1 : 0);
    logic [GAP_W-1:0]    gap_q, gap_n;
`else
    logic                others_req;
`endif

    m8088_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (req),
        .last     (rr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_n   = state_q;
        hold_n    = HOLD;
        gnt_n     = gnt;
        err_n     = err;
        cnt_n     = cnt_q;
        rr_n      = rr_q;
        owner_req = |(req & gnt);
`ifdef M8088_ARB_CPU_FAIRNESS_EN
        gap_n     = gap_q;
`else
        others_req = |(req & ~gnt);
`endif
        case (state_q)
            IDLE: begin
                hold_n = 1'b0;
                gnt_n  = '0;
                if (|req && !HOLDA) begin
                    hold_n  = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                hold_n = 1'b1;
                if (HOLDA) begin
                    if (pick_valid) begin
                        gnt_n   = pick;
                        rr_n    = pick_idx;
                        cnt_n   = '0;
                        state_n = GRANT;
                    end else begin
                        hold_n  = 1'b0;
                        state_n = RELEASE;
                    end
                end
            end
            GRANT: begin
                if (!HOLDA) begin
                    err_n   = 1'b1;
                    gnt_n   = '0;
                    hold_n  = 1'b0;
                    state_n = RELEASE;
                end else if (!owner_req) begin
                    gnt_n = '0;
`ifdef M8088_ARB_CPU_FAIRNESS_EN
                    hold_n  = 1'b0;
                    state_n = RELEASE;
`else
                    if (others_req) begin
                        state_n = HANDOVER;
                    end else begin
                        hold_n  = 1'b0;
                        state_n = RELEASE;
                    end
`endif
                end else if (cnt_q != '1) begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`ifndef M8088_ARB_CPU_FAIRNESS_EN
            HANDOVER: begin
                gnt_n = '0;
                // Never grant onto a bus the CPU has already taken back.
                if (HOLDA && pick_valid) begin
                    gnt_n   = pick;
                    rr_n    = pick_idx;
                    cnt_n   = '0;
                    state_n = GRANT;
                end else begin
                    hold_n  = 1'b0;
                    state_n = RELEASE;
                end
            end
`endif
            RELEASE: begin
                hold_n = 1'b0;
                gnt_n  = '0;
                if (!HOLDA) begin
`ifdef M8088_ARB_CPU_FAIRNESS_EN
                    gap_n   = '0;
                    state_n = GAP;
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef M8088_ARB_CPU_FAIRNESS_EN
            GAP: begin
                hold_n = 1'b0;
                gnt_n  = '0;
                if (gap_q == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end
`endif
            default: begin
                hold_n  = 1'b0;
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        preempt_n = (MAX_TENURE != 0) && (gnt_n != '0) &&
                    (32'(cnt_n) >= 32'(MAX_TENURE - 1));
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge CORE_CLK) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            HOLD    <= 1'b0;
            gnt     <= '0;
            preempt <= 1'b0;
            err     <= 1'b0;
            cnt_q   <= '0;
            rr_q    <= RR_IDX_W'(NUM_REQ - 1);
`ifdef M8088_ARB_CPU_FAIRNESS_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            HOLD    <= hold_n;
            gnt     <= gnt_n;
            preempt <= preempt_n;
            err     <= err_n;
            cnt_q   <= cnt_n;
            rr_q    <= rr_n;
`ifdef M8088_ARB_CPU_FAIRNESS_EN
            gap_q   <= gap_n;
`endif
        end
    end

endmodule

// File: tb/tb_m8088_hold_arbiter.sv
// Directed self-checking bench for m8088_hold_arbiter (default build).
module tb_m8088_hold_arbiter;

    logic       CORE_CLK = 1'b0;
    logic       RESET_n;
    logic [1:0] req;
    logic       HOLDA;
    logic       HOLD;
    logic [1:0] gnt;
    logic       preempt;
    logic       err;

    int checks = 0;
    int errors = 0;

    m8088_hold_arbiter #(
        .NUM_REQ    (2),
        .MAX_TENURE (4),
        .CPU_GAP    (8)
    ) dut (
        .CORE_CLK (CORE_CLK),
        .RESET_n  (RESET_n),
        .req      (req),
        .HOLDA    (HOLDA),
        .HOLD     (HOLD),
        .gnt      (gnt),
        .preempt  (preempt),
        .err      (err)
    );

    always #5 CORE_CLK = ~CORE_CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check one-hot grant.
    task automatic tick();
        @(posedge CORE_CLK);
        #1;
        chk("gnt_onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
    endtask

    initial begin
        RESET_n = 1'b0;
        req     = 2'b00;
        HOLDA   = 1'b0;
        tick();
        tick();
        chk("rst_HOLD", {7'd0, HOLD}, 8'd0);
        chk("rst_gnt", {6'd0, gnt}, 8'd0);
        chk("rst_preempt", {7'd0, preempt}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        RESET_n = 1'b1;

        // Single requester
        req = 2'b01;
        tick();
        chk("s_HOLD_up", {7'd0, HOLD}, 8'd1);
        chk("s_gnt_wait", {6'd0, gnt}, 8'd0);
        tick();
        tick();
        chk("s_gnt_wait2", {6'd0, gnt}, 8'd0);
        HOLDA = 1'b1;
        tick();
        chk("s_gnt", {6'd0, gnt}, 8'h01);
        tick();
        tick();
        chk("s_gnt_hold", {6'd0, gnt}, 8'h01);
        chk("s_no_preempt", {7'd0, preempt}, 8'd0);
        req = 2'b00;
        tick();
        chk("s_gnt_drop", {6'd0, gnt}, 8'd0);
        chk("s_HOLD_drop", {7'd0, HOLD}, 8'd0);
        tick();
        chk("s_release_HOLD", {7'd0, HOLD}, 8'd0);
        HOLDA = 1'b0;
        tick();
        tick();
        chk("s_idle_HOLD", {7'd0, HOLD}, 8'd0);

        // Preempt with MAX_TENURE=4
        req = 2'b01;
        tick();
        chk("p_HOLD_up", {7'd0, HOLD}, 8'd1);
        HOLDA = 1'b1;
        tick();
        chk("p_gnt", {6'd0, gnt}, 8'h01);
        chk("p_pre_c1", {7'd0, preempt}, 8'd0);
        tick();
        tick();
        chk("p_pre_c3", {7'd0, preempt}, 8'd0);
        tick();
        chk("p_pre_c4", {7'd0, preempt}, 8'd1);
        tick();
        chk("p_pre_c5", {7'd0, preempt}, 8'd1);
        tick();
        chk("p_pre_c6", {7'd0, preempt}, 8'd1);
        chk("p_gnt_c6", {6'd0, gnt}, 8'h01);
        req = 2'b00;
        tick();
        chk("p_pre_drop", {7'd0, preempt}, 8'd0);
        chk("p_gnt_drop", {6'd0, gnt}, 8'd0);
        HOLDA = 1'b0;
        tick();

        // Protocol error: HOLDA falls during GRANT
        req = 2'b10;
        tick();
        chk("e_HOLD_up", {7'd0, HOLD}, 8'd1);
        HOLDA = 1'b1;
        tick();
        chk("e_gnt", {6'd0, gnt}, 8'h02);
        HOLDA = 1'b0;
        tick();
        chk("e_err", {7'd0, err}, 8'd1);
        chk("e_gnt_drop", {6'd0, gnt}, 8'd0);
        chk("e_HOLD_drop", {7'd0, HOLD}, 8'd0);
        tick();
        tick();
        chk("e_HOLD_again", {7'd0, HOLD}, 8'd1);
        chk("e_err_sticky", {7'd0, err}, 8'd1);
        HOLDA = 1'b1;
        tick();
        chk("e_gnt_again", {6'd0, gnt}, 8'h02);
        chk("e_err_sticky2", {7'd0, err}, 8'd1);

        // Reset during GRANT, then during WAIT_ACK
        req     = 2'b11;
        RESET_n = 1'b0;
        tick();
        chk("r_grant_HOLD", {7'd0, HOLD}, 8'd0);
        chk("r_grant_gnt", {6'd0, gnt}, 8'd0);
        chk("r_grant_err", {7'd0, err}, 8'd0);
        RESET_n = 1'b1;
        HOLDA   = 1'b0;
        tick();
        chk("r_wait_HOLD", {7'd0, HOLD}, 8'd1);
        RESET_n = 1'b0;
        tick();
        chk("r_wait_HOLD0", {7'd0, HOLD}, 8'd0);
        chk("r_wait_gnt0", {6'd0, gnt}, 8'd0);
        RESET_n = 1'b1;
        tick();
        chk("r_HOLD_re", {7'd0, HOLD}, 8'd1);
        HOLDA = 1'b1;
        tick();
        chk("r_first_req0", {6'd0, gnt}, 8'h01);

        // Round-robin handover: owners 01,10,01,10
        for (int k = 0; k < 3; k++) begin
            logic [1:0] own;
            logic [1:0] nxt;
            own = (k % 2 == 0) ? 2'b01 : 2'b10;
            nxt = (k % 2 == 0) ? 2'b10 : 2'b01;
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("rr_gnt_hold", {6'd0, gnt}, {6'd0, own});
                chk("rr_HOLD_hold", {7'd0, HOLD}, 8'd1);
            end
            req = nxt;
            tick();
            chk("rr_dead_gnt", {6'd0, gnt}, 8'd0);
            chk("rr_dead_HOLD", {7'd0, HOLD}, 8'd1);
            chk("rr_dead_preempt", {7'd0, preempt}, 8'd0);
            req = 2'b11;
            tick();
            chk("rr_next_gnt", {6'd0, gnt}, {6'd0, nxt});
            chk("rr_next_HOLD", {7'd0, HOLD}, 8'd1);
        end

        // Final release
        req = 2'b00;
        tick();
        chk("f_gnt", {6'd0, gnt}, 8'd0);
        chk("f_HOLD", {7'd0, HOLD}, 8'd0);
        HOLDA = 1'b0;
        tick();
        tick();
        chk("f_idle_HOLD", {7'd0, HOLD}, 8'd0);
        chk("f_err_clean", {7'd0, err}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
